// File: rtl/data_memory_responder_pkg.sv
// rtl/data_memory_responder_pkg.sv - shared types and helpers for the data-memory responder
package dmem_pkg;

  localparam int WORD_W    = 32;
  // Widest word index a 32-bit byte address can carry; buffer entries store this width.
  localparam int MAX_IDX_W = 30;

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] index;
    logic [WORD_W-1:0]    data;
  } wb_entry_t;

  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// rtl/data_memory_responder_if.sv - core-to-responder data-memory port
interface data_memory_responder_if;
  import dmem_pkg::*;

  logic              MemoryWrite;
  logic              MemoryRead;
  logic [31:0]       dataAddress;
  logic [WORD_W-1:0] WriteData;
  logic [WORD_W-1:0] ReadData;
  logic              MemStall;

  modport master (
    output MemoryWrite, MemoryRead, dataAddress, WriteData,
    input  ReadData, MemStall
  );

  modport slave (
    input  MemoryWrite, MemoryRead, dataAddress, WriteData,
    output ReadData, MemStall
  );

endinterface

// File: rtl/data_memory_responder_write_buffer.sv
// rtl/data_memory_responder_write_buffer.sv - coalescing posted-write FIFO, hit_data port only with DMEM_FORWARD_EN
module write_buffer
  import dmem_pkg::*;
#(
  parameter int WB_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 coalesce,
  input  logic [MAX_IDX_W-1:0] index,
  input  logic [WORD_W-1:0]    wr_data,
  output logic                 hit,
`ifdef DMEM_FORWARD_EN
  output logic [WORD_W-1:0]    hit_data,
`endif
  output wb_entry_t            head,
  output logic                 full,
  output logic                 empty
);

  localparam int PW = $clog2(WB_DEPTH);

  wb_entry_t     mem [WB_DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic [PW-1:0] hit_pos;
  logic [PW:0]   count;

  assign head  = mem[head_ptr];
  assign full  = (count == (PW+1)'(WB_DEPTH));
  assign empty = (count == '0);

  // Associative lookup; coalescing guarantees at most one valid entry per index.
  always_comb begin
    hit     = 1'b0;
    hit_pos = '0;
`ifdef DMEM_FORWARD_EN
    hit_data = '0;
`endif
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (mem[i].valid && (mem[i].index == index)) begin
        hit     = 1'b1;
        hit_pos = PW'(i);
`ifdef DMEM_FORWARD_EN
        hit_data = mem[i].data;
`endif
      end
    end
  end

  // FIFO storage and pointers; a full-buffer push lands in the slot being popped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      for (int i = 0; i < WB_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (coalesce) mem[hit_pos].data <= wr_data;
      if (pop) begin
        mem[head_ptr].valid <= 1'b0;
        head_ptr            <= head_ptr + 1'b1;
      end
      if (push) begin
        mem[tail_ptr] <= '{valid: 1'b1, index: index, data: wr_data};
        tail_ptr      <= tail_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - data-memory responder: RAM, posted-write buffer, forwarding under DMEM_FORWARD_EN
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH    = 256,
  parameter int WB_DEPTH = 4
) (
  input logic                     clk,
  input logic                     rst,
  data_memory_responder_if.slave  bus
);

  localparam int IW = idx_width(DEPTH);

  logic [WORD_W-1:0] ram [DEPTH];
  logic [IW-1:0]     word_idx;
  logic              push, pop, coalesce, do_read, stall;
  logic              hit, full, empty;
  wb_entry_t         head;
  logic [WORD_W-1:0] rd_data;
`ifdef DMEM_FORWARD_EN
  logic [WORD_W-1:0] hit_data;
`endif

  // Byte offset and bits above the index are ignored, so addresses alias modulo DEPTH.
  assign word_idx = bus.dataAddress[IW+1:2];

  logic unused_bits;
  assign unused_bits = ^{bus.dataAddress[31:IW+2], bus.dataAddress[1:0],
                         head.valid, head.index[MAX_IDX_W-1:IW]};

  write_buffer #(.WB_DEPTH(WB_DEPTH)) u_wb (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .coalesce (coalesce),
    .index    (MAX_IDX_W'(word_idx)),
    .wr_data  (bus.WriteData),
    .hit      (hit),
`ifdef DMEM_FORWARD_EN
    .hit_data (hit_data),
`endif
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  // Port arbitration: store wins, loads own the RAM port, idle cycles drain the buffer.
  always_comb begin
    push     = 1'b0;
    pop      = 1'b0;
    coalesce = 1'b0;
    do_read  = 1'b0;
    stall    = 1'b0;
    if (bus.MemoryWrite) begin
      if (hit) begin
        coalesce = 1'b1;
      end else begin
        push = 1'b1;
        pop  = full;
      end
    end else if (bus.MemoryRead) begin
`ifdef DMEM_FORWARD_EN
      do_read = 1'b1;
`else
      if (hit) begin
        stall = 1'b1;
        pop   = 1'b1;
      end else begin
        do_read = 1'b1;
      end
`endif
    end else begin
      pop = !empty;
    end
  end

  assign bus.MemStall = stall;
  assign bus.ReadData = rd_data;

  // Retiring head entry writes the single RAM port; never coincides with a load read.
  always_ff @(posedge clk) begin
    if (pop) ram[head.index[IW-1:0]] <= head.data;
  end

  // Registered load result, held until the next accepted load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (do_read) begin
`ifdef DMEM_FORWARD_EN
      rd_data <= hit ? hit_data : ram[word_idx];
`else
      rd_data <= ram[word_idx];
`endif
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - self-checking bench for data_memory_responder
module tb_data_memory_responder;

  localparam int DEPTH    = 256;
  localparam int WB_DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  data_memory_responder_if bus ();

  data_memory_responder #(.DEPTH(DEPTH), .WB_DEPTH(WB_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mram [int];
  logic [31:0] m_rd    = '0;
  bit          m_known = 1'b1;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic int find(input int i);
    foreach (q[k]) if (q[k].idx == i) return k;
    return -1;
  endfunction

  function automatic void retire();
    mram[q[0].idx] = q[0].data;
    void'(q.pop_front());
  endfunction

  function automatic bit model_stall();
`ifdef DMEM_FORWARD_EN
    return 1'b0;
`else
    return bus.MemoryRead && !bus.MemoryWrite && (find(widx(bus.dataAddress)) >= 0);
`endif
  endfunction

  // Reference model: ordered list of pending stores in front of a sparse memory.
  initial begin
    int i, k;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        q.delete();
        m_rd    = '0;
        m_known = 1'b1;
      end else begin
        i = widx(bus.dataAddress);
        k = find(i);
        if (bus.MemoryWrite) begin
          if (k >= 0) q[k].data = bus.WriteData;
          else begin
            if (q.size() == WB_DEPTH) retire();
            q.push_back('{idx: i, data: bus.WriteData});
          end
        end else if (bus.MemoryRead) begin
          if (k >= 0) begin
`ifdef DMEM_FORWARD_EN
            m_rd    = q[k].data;
            m_known = 1'b1;
`else
            retire();
`endif
          end else if (mram.exists(i)) begin
            m_rd    = mram[i];
            m_known = 1'b1;
          end else begin
            m_known = 1'b0;
          end
        end else if (q.size() > 0) begin
          retire();
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      checks++;
      if (bus.MemStall !== model_stall()) begin
        errors++;
        $display("FAIL cmp_stall: got %b expected %b", bus.MemStall, model_stall());
      end
      checks++;
      if (int'(dut.u_wb.count) != q.size()) begin
        errors++;
        $display("FAIL cmp_count: got %0d expected %0d", dut.u_wb.count, q.size());
      end
      if (m_known) begin
        checks++;
        if (bus.ReadData !== m_rd) begin
          errors++;
          $display("FAIL cmp_rd: got %h expected %h", bus.ReadData, m_rd);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    bus.MemoryWrite = w;
    bus.MemoryRead  = r;
    bus.dataAddress = a;
    bus.WriteData   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, a, d);
  endtask

  task automatic load(input logic [31:0] a);
    int n;
    bus.MemoryWrite = 1'b0;
    bus.MemoryRead  = 1'b1;
    bus.dataAddress = a;
    bus.WriteData   = '0;
    n = 0;
    @(negedge clk);
    while (bus.MemStall && n < 16) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n >= 16) begin
      errors++;
      $display("FAIL load_timeout: got stall after %0d cycles expected release", n);
    end
    @(posedge clk);
    #1;
    bus.MemoryRead = 1'b0;
  endtask

  initial begin
    logic [31:0] vals [3];
    bus.MemoryWrite = 1'b0;
    bus.MemoryRead  = 1'b0;
    bus.dataAddress = '0;
    bus.WriteData   = '0;
    #3 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_rd", bus.ReadData, 32'h0);
    chk("reset_stall", {31'b0, bus.MemStall}, 32'h0);
    chk("reset_count", 32'(dut.u_wb.count), 32'd0);

    load(32'h10);

    store(32'h20, 32'hDEADBEEF);
    load(32'h20);
    chk("store_then_load", bus.ReadData, 32'hDEADBEEF);
    idle(4);

    store(32'h40, 32'h1);
    chk("coalesce_cnt1", 32'(dut.u_wb.count), 32'd1);
    store(32'h40, 32'h2);
    chk("coalesce_cnt2", 32'(dut.u_wb.count), 32'd1);
    idle(4);
    chk("drained_cnt", 32'(dut.u_wb.count), 32'd0);
    load(32'h40);
    chk("coalesce_data", bus.ReadData, 32'h2);

    for (int k = 0; k < 5; k++) store(32'(4 * k), 32'hA0 + 32'(k));
    chk("full_cnt", 32'(dut.u_wb.count), 32'd4);
    for (int k = 0; k < 5; k++) begin
      load(32'(4 * k));
      chk($sformatf("full_load_%0d", k), bus.ReadData, 32'hA0 + 32'(k));
    end
    idle(6);

    store(32'h400, 32'h55AA);
    idle(2);
    load(32'h0);
    chk("alias_load0", bus.ReadData, 32'h55AA);
    load(32'h400);
    chk("alias_load400", bus.ReadData, 32'h55AA);

    step(1'b1, 1'b1, 32'h44, 32'h77);
    chk("both_hold", bus.ReadData, 32'h55AA);
    idle(2);
    load(32'h44);
    chk("both_store", bus.ReadData, 32'h77);

    vals[0] = 32'h11;
    vals[1] = 32'h22;
    vals[2] = 32'h33;
    for (int k = 0; k < 3; k++) store(32'h100 + 32'(4 * k), vals[k]);
    idle(5);
    for (int k = 0; k < 3; k++) store(32'h100 + 32'(4 * k), 32'h99 - 32'(k));
    chk("pre_reset_cnt", 32'(dut.u_wb.count), 32'd3);
    bus.MemoryWrite = 1'b0;
    rst = 1'b0;
    #1;
    chk("async_reset_cnt", 32'(dut.u_wb.count), 32'd0);
    chk("async_reset_rd", bus.ReadData, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      load(32'h100 + 32'(4 * k));
      chk($sformatf("post_reset_%0d", k), bus.ReadData, vals[k]);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
